// File: rtl/show_sw_scan.sv
// Switch-to-hex display block: syncs and debounces NUM_DIGITS nibbles of
// active-low switches, scans the inverted value onto a multiplexed 7-segment
// display, and keeps a short history of previously accepted values for the LEDs.

// Hex nibble to {a,b,c,d,e,f,g} segment pattern, segments active-high.
module show_sw_hex7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // Pure lookup, one instance per digit.
  always_comb begin
    seg = 7'h00;
    unique case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = 7'h00;
    endcase
  end
endmodule

module show_sw_scan #(
  parameter int NUM_DIGITS      = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_CYCLES     = 8,
  parameter int HIST_DEPTH      = 4,
  localparam int SW_W           = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SW_W-1:0]       switch,
  input  logic [7:0]            hist_sel,
  output logic [NUM_DIGITS-1:0] num_csn,
  output logic [6:0]            num_a_g,
  output logic [SW_W-1:0]       led,
  output logic                  chg_pulse,
  output logic [7:0]            chg_cnt
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [SW_W-1:0]                 s1, s2, cand, stable;
  logic [CNT_W-1:0]                cnt;
  logic [HIST_DEPTH-1:0][SW_W-1:0] hist;
  logic [SW_W-1:0]                 disp_val;
  logic [SW_W-1:0]                 led_nxt;
  logic [NUM_DIGITS-1:0][6:0]      seg;
  logic [TMR_W-1:0]                tmr;
  logic [IDX_W-1:0]                idx;

  // Switches are active-low, so the shown value is the inverse of the stable one.
  assign disp_val = ~stable;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    show_sw_hex7 u_hex7 (
      .nib (disp_val[4*d +: 4]),
      .seg (seg[d])
    );
  end

  // Synchroniser, debounce, accept, history push and change counting.
  // The counter saturates at its terminal value so a held candidate that
  // already matches the stable value never re-fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '1;
      s2        <= '1;
      cand      <= '1;
      stable    <= '1;
      cnt       <= '0;
      hist      <= '0;
      chg_pulse <= 1'b0;
      chg_cnt   <= 8'h00;
    end else begin
      s1        <= switch;
      s2        <= s1;
      chg_pulse <= 1'b0;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        if (cand != stable) begin
          stable    <= cand;
          hist[0]   <= disp_val;
          for (int k = 1; k < HIST_DEPTH; k++) hist[k] <= hist[k-1];
          chg_pulse <= 1'b1;
          if (chg_cnt != 8'hFF) chg_cnt <= chg_cnt + 8'h01;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // History entry selected for the LEDs; out-of-range selects show zero.
  always_comb begin
    led_nxt = '0;
    for (int k = 0; k < HIST_DEPTH; k++)
      if (hist_sel == 8'(k)) led_nxt = hist[k];
  end

  // LED register, one cycle behind hist/hist_sel.
  always_ff @(posedge clk) begin
    if (reset) led <= '0;
    else       led <= led_nxt;
  end

  // Digit scan: outputs are built from the current idx, then timer/idx advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr     <= '0;
      idx     <= '0;
      num_csn <= '1;
      num_a_g <= 7'h00;
    end else begin
      num_csn <= ~(NUM_DIGITS'(1) << idx);
      num_a_g <= seg[idx];
      if (tmr == TMR_MAX) begin
        tmr <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_show_sw_scan.sv
// Bench for show_sw_scan at default parameters: directed vector table,
// hand-written timing/reset/saturation sequences, then randomized stimulus
// checked every cycle against a sliding-window reference model.
module tb_show_sw_scan;
  localparam int ND = 2;
  localparam int DB = 4;
  localparam int SC = 8;
  localparam int HD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] switch;
  logic [7:0] hist_sel;
  logic [1:0] num_csn;
  logic [6:0] num_a_g;
  logic [7:0] led;
  logic       chg_pulse;
  logic [7:0] chg_cnt;

  int tests = 0;
  int fails = 0;
  bit mdl_on = 1'b0;

  logic [6:0] hx [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  show_sw_scan #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .SCAN_CYCLES(SC), .HIST_DEPTH(HD)) dut (
    .clk       (clk),
    .reset     (reset),
    .switch    (switch),
    .hist_sel  (hist_sel),
    .num_csn   (num_csn),
    .num_a_g   (num_a_g),
    .led       (led),
    .chg_pulse (chg_pulse),
    .chg_cnt   (chg_cnt)
  );

  always #5 clk = ~clk;

  // Reference model. A value is accepted once the synchronised switches have
  // shown it for DB+1 consecutive edges with no reset in the last DB edges,
  // and it differs from the current stable value.
  logic [7:0] m_s1, m_s2, m_stable, m_disp;
  logic [7:0] m_win [DB+1];
  logic [7:0] m_hist [HD];
  logic [7:0] m_cnt;
  int         m_run, m_t, m_dig;
  bit         m_eq;
  logic       e_pulse;
  logic [7:0] e_led;
  logic [1:0] e_csn;
  logic [6:0] e_ag;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 8'hFF; m_s2 = 8'hFF; m_stable = 8'hFF;
      for (int i = 0; i <= DB; i++) m_win[i] = 8'hFF;
      for (int i = 0; i < HD; i++) m_hist[i] = 8'h00;
      m_cnt = 0; m_run = 0; m_t = 0;
      e_pulse = 0; e_led = 0; e_csn = 2'b11; e_ag = 0;
    end else begin
      m_disp = ~m_stable;
      e_led  = (hist_sel < HD) ? m_hist[hist_sel[1:0]] : 8'h00;
      m_dig  = (m_t / SC) % ND;
      m_t++;
      e_csn  = ~(2'b01 << m_dig);
      e_ag   = hx[m_disp[4*m_dig +: 4]];
      for (int i = DB; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = m_s2;
      m_s2 = m_s1;
      m_s1 = switch;
      if (m_run < DB) m_run++;
      m_eq = 1'b1;
      for (int i = 1; i <= DB; i++) if (m_win[i] != m_win[0]) m_eq = 1'b0;
      e_pulse = 1'b0;
      if (m_run >= DB && m_eq && m_win[0] != m_stable) begin
        for (int i = HD-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = m_disp;
        m_stable  = m_win[0];
        e_pulse   = 1'b1;
        if (m_cnt != 8'hFF) m_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (mdl_on) begin
      check("mdl_csn",   num_csn,   e_csn);
      check("mdl_a_g",   num_a_g,   e_ag);
      check("mdl_led",   led,       e_led);
      check("mdl_pulse", chg_pulse, e_pulse);
      check("mdl_cnt",   chg_cnt,   m_cnt);
    end
  endtask

  typedef struct {
    logic [7:0] sw;
    logic [7:0] sel;
    int         hold;
    bit         chk;
    logic [7:0] cnt;
    logic [7:0] led;
    logic [7:0] disp;
  } vec_t;

  vec_t vt [15];

  initial begin
    int         first, pulses;
    bit         found;
    logic [1:0] one;
    logic [7:0] dv;

    vt[0]  = '{8'h87, 8'd0, 20, 1'b1, 8'd1, 8'h00, 8'h78};
    vt[1]  = '{8'h00, 8'd0,  3, 1'b0, 8'd1, 8'h00, 8'h78}; // glitch, 3 cycles
    vt[2]  = '{8'h87, 8'd0, 20, 1'b1, 8'd1, 8'h00, 8'h78};
    vt[3]  = '{8'hE9, 8'd0, 20, 1'b1, 8'd2, 8'h78, 8'h16};
    vt[4]  = '{8'h1E, 8'd0, 20, 1'b1, 8'd3, 8'h16, 8'hE1};
    vt[5]  = '{8'h1E, 8'd1,  4, 1'b1, 8'd3, 8'h78, 8'hE1};
    vt[6]  = '{8'h1E, 8'd2,  4, 1'b1, 8'd3, 8'h00, 8'hE1};
    vt[7]  = '{8'h1E, 8'd4,  4, 1'b1, 8'd3, 8'h00, 8'hE1};
    vt[8]  = '{8'h5A, 8'd0, 20, 1'b1, 8'd4, 8'hE1, 8'hA5};
    vt[9]  = '{8'h3C, 8'd0, 20, 1'b1, 8'd5, 8'hA5, 8'hC3};
    vt[10] = '{8'hF0, 8'd0, 20, 1'b1, 8'd6, 8'hC3, 8'h0F};
    vt[11] = '{8'h0F, 8'd0, 20, 1'b1, 8'd7, 8'h0F, 8'hF0};
    vt[12] = '{8'h66, 8'd0, 20, 1'b1, 8'd8, 8'hF0, 8'h99};
    vt[13] = '{8'h66, 8'd3,  4, 1'b1, 8'd8, 8'hA5, 8'h99};
    vt[14] = '{8'h66, 8'd2,  4, 1'b1, 8'd8, 8'hC3, 8'h99};

    // Reset held 5 cycles with all switches released.
    reset = 1'b1; switch = 8'hFF; hist_sel = 8'd0;
    for (int i = 0; i < 5; i++) tick();
    mdl_on = 1'b1;
    check("rst_csn", num_csn, 2'b11);
    check("rst_a_g", num_a_g, 7'h00);
    check("rst_led", led, 8'h00);
    check("rst_cnt", chg_cnt, 8'h00);
    reset = 1'b0;
    for (int i = 1; i <= 2*SC; i++) begin
      tick();
      check("scan_csn", num_csn, (i <= SC) ? 2'b10 : 2'b01);
      check("scan_a_g", num_a_g, 7'h7E);
    end

    // First accepted change pulses exactly DB+3 edges after the switch moves.
    switch = 8'h87;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (chg_pulse && first == 0) first = i;
    end
    check("pulse_lat", first, DB + 3);

    // Directed vector table.
    foreach (vt[n]) begin
      switch = vt[n].sw; hist_sel = vt[n].sel;
      for (int i = 0; i < vt[n].hold; i++) tick();
      if (vt[n].chk) begin
        check($sformatf("vec%0d_cnt", n), chg_cnt, vt[n].cnt);
        check($sformatf("vec%0d_led", n), led, vt[n].led);
        dv = vt[n].disp;
        for (int i = 0; i < 2*SC; i++) begin
          tick();
          for (int d = 0; d < ND; d++) begin
            one = 2'b01 << d;
            if (num_csn == ~one) check($sformatf("vec%0d_dig%0d", n, d), num_a_g, hx[dv[4*d +: 4]]);
          end
        end
      end
    end

    // Reset mid-scan (digit 1 active) and mid-debounce.
    hist_sel = 8'd3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (num_csn == 2'b01) found = 1'b1;
    end
    check("wait_dig1", found, 1'b1);
    switch = 8'h11;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1; switch = 8'hFF;
    tick();
    check("mid_rst_csn", num_csn, 2'b11);
    check("mid_rst_a_g", num_a_g, 7'h00);
    check("mid_rst_led", led, 8'h00);
    check("mid_rst_pulse", chg_pulse, 1'b0);
    check("mid_rst_cnt", chg_cnt, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("post_rst_cnt", chg_cnt, 8'h00);
    check("post_rst_led", led, 8'h00);

    // Saturation: 300 alternating accepted changes.
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      switch = (c % 2 == 0) ? 8'h00 : 8'hFF;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (chg_pulse) pulses++;
      end
    end
    check("sat_cnt", chg_cnt, 8'hFF);
    check("sat_pulses", pulses, 300);

    // Randomized stimulus, including glitches and occasional resets.
    for (int r = 0; r < 400; r++) begin
      switch   = 8'($urandom);
      hist_sel = 8'($urandom_range(0, 5));
      reset    = ($urandom_range(0, 39) == 0);
      for (int i = $urandom_range(1, 9); i > 0; i--) begin
        tick();
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
